// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Four-way round-robin arbiter in front of a single UART
//               transmitter. A requester raises req[i] with its byte on
//               req_data[8i+7:8i]; the arbiter picks a winner, latches the
//               byte, fires a one-cycle tx_start together with a one-cycle
//               req_ack[i], then waits for tx_done before arbitrating again.
//
// Ports       : sys_clk      i  system clock, rising edge
//               rst          i  synchronous active-high reset
//               req[3:0]     i  level requests, held until acked
//               req_data     i  packed request bytes, 8 bits per requester
//               req_ack[3:0] o  one-cycle ack to the granted requester
//               tx_start     o  one-cycle start pulse to the transmitter
//               tx_data[7:0] o  latched byte, held until the next grant
//               tx_done      i  one-cycle end-of-frame pulse from transmitter
//               grant_id[1:0]o  requester currently or last served
//               busy         o  high while a transfer is in flight
//               timeout_err  o  one-cycle pulse on watchdog expiry
//
// Options     : UART_ARB_TIMEOUT_EN - when defined, a watchdog aborts a
//               transfer that sees no tx_done within TIMEOUT_CYC WAIT cycles.
//               When undefined, WAIT is unbounded and timeout_err is 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ack,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        timeout_err
);

    // Elaboration-time sanity checks on the configuration.
    if (NREQ != 4) begin : g_nreq_check
        $error("uart_tx_arb: NREQ must be 4");
    end
    if (TIMEOUT_CYC < 1) begin : g_timeout_check
        $error("uart_tx_arb: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_tx_start;
    logic [3:0]  r_req_ack;
    logic [7:0]  r_tx_data;
    logic [1:0]  r_grant_id;
    logic [1:0]  r_last_grant;
    logic        r_busy;

    logic [1:0]  w_win;
    logic [7:0]  w_win_byte;

    // ------------------------------------------------------------------------
    // Round-robin pick. Candidates are visited from the farthest offset
    // (last_grant itself) down to the nearest (last_grant+1); the last match
    // assigned wins, so the nearest requesting index after last_grant is
    // selected. The 2-bit index arithmetic provides the mod-4 wrap.
    // ------------------------------------------------------------------------
    always_comb begin
        w_win = r_last_grant;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[r_last_grant + 2'(i)]) begin
                w_win = r_last_grant + 2'(i);
            end
        end
    end

    assign w_win_byte = req_data[{w_win, 3'b000} +: 8];

`ifdef UART_ARB_TIMEOUT_EN
    localparam int                c_WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT_CYC - 1);

    logic [c_WD_W-1:0] r_wdog;
    logic              r_timeout_err;
`endif

    // ------------------------------------------------------------------------
    // Main FSM. All outputs are registered; tx_start and req_ack are raised
    // on the grant edge so they are visible during the START cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_tx_start    <= 1'b0;
            r_req_ack     <= 4'b0000;
            r_tx_data     <= 8'h00;
            r_grant_id    <= 2'd0;
            r_last_grant  <= 2'd3;
            r_busy        <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            r_tx_start    <= 1'b0;
            r_req_ack     <= 4'b0000;
`ifdef UART_ARB_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // tx_done here is meaningless and deliberately ignored.
                    if (|req) begin
                        r_tx_data    <= w_win_byte;
                        r_grant_id   <= w_win;
                        r_last_grant <= w_win;
                        r_tx_start   <= 1'b1;
                        r_req_ack    <= 4'b0001 << w_win;
                        r_busy       <= 1'b1;
                        r_state      <= S_START;
                    end
                end

                S_START: begin
                    // A tx_done arriving here belongs to no frame of ours.
                    r_state <= S_WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    r_wdog  <= '0;
`endif
                end

                S_WAIT: begin
                    if (tx_done) begin
                        // tx_done wins over a simultaneous watchdog expiry.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (r_wdog == c_WD_MAX) begin
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ack  = r_req_ack;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

`ifdef UART_ARB_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Self-checking bench for uart_tx_arb. Directed scenarios plus
//               a randomized run checked against a round-robin reference
//               model (offset search from the last grant, mod 4).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_arb;

    localparam int c_TIMEOUT = 100;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    int n_run  = 0;
    int n_fail = 0;
    int m_last = 3;   // reference model: last granted requester

    always #4 sys_clk = ~sys_clk;

    uart_tx_arb #(
        .NREQ        (4),
        .TIMEOUT_CYC (c_TIMEOUT)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Reference arbitration: first requesting index at offset 1..4 from last.
    function automatic int rr_pick(input int last, input logic [3:0] mask);
        for (int k = 1; k <= 4; k++) begin
            if (mask[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = 4'b0000;
        tx_done  = 1'b0;
        req_data = $urandom;
        tick();
        tick();
        rst    = 1'b0;
        m_last = 3;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_run++; if (tx_start !== 1'b0)     begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        n_run++; if (req_ack !== 4'b0000)   begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", req_ack); end
        n_run++; if (tx_data !== 8'h00)     begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_run++; if (grant_id !== 2'd0)     begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        n_run++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_run++; if (timeout_err !== 1'b0)  begin n_fail++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        tick();
        n_run++; if (busy !== 1'b0 || tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_idle_hold: busy=%b tx_start=%b expected 0/0", busy, tx_start); end
    endtask

    task automatic test_single();
        do_reset();
        req_data = {$urandom_range(0, 255), 24'h0} | (32'hA5 << 16) | 32'(8'($urandom));
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        tick();
        n_run++; if (tx_start !== 1'b1)   begin n_fail++; $display("FAIL single_start: got %b expected 1", tx_start); end
        n_run++; if (tx_data !== 8'hA5)   begin n_fail++; $display("FAIL single_data: got %h expected a5", tx_data); end
        n_run++; if (req_ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack: got %b expected 0100", req_ack); end
        n_run++; if (grant_id !== 2'd2)   begin n_fail++; $display("FAIL single_gid: got %0d expected 2", grant_id); end
        n_run++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL single_busy_start: got %b expected 1", busy); end
        req = 4'b0000;
        tick();
        n_run++; if (tx_start !== 1'b0 || req_ack !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_width: tx_start=%b ack=%b expected 0/0000", tx_start, req_ack); end
        repeat (5) tick();
        n_run++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL single_busy_wait: got %b expected 1", busy); end
        pulse_done();
        n_run++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL single_busy_after_done: got %b expected 0", busy); end
        n_run++; if (tx_data !== 8'hA5)   begin n_fail++; $display("FAIL single_data_held: got %h expected a5", tx_data); end
    endtask

    task automatic test_round_robin();
        logic [7:0] bytes [4];
        int exp;
        bool_loop: begin end
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
        do_reset();
        req_data = 32'h4433_2211;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            for (int w = 0; w < 4 && tx_start !== 1'b1; w++) tick();
            exp = rr_pick(m_last, req);
            m_last = exp;
            n_run++; if (tx_start !== 1'b1) begin n_fail++; $display("FAIL rr_start[%0d]: got %b expected 1", n, tx_start); end
            n_run++; if (grant_id !== exp[1:0] || tx_data !== bytes[exp]) begin n_fail++; $display("FAIL rr_grant[%0d]: got id=%0d data=%h expected id=%0d data=%h", n, grant_id, tx_data, exp, bytes[exp]); end
            n_run++; if (req_ack !== (4'b0001 << exp)) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b expected %b", n, req_ack, 4'b0001 << exp); end
            repeat (49) tick();
            pulse_done();
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        int exp_seq [3];
        exp_seq[0] = 0; exp_seq[1] = 3; exp_seq[2] = 0;
        do_reset();
        req_data = $urandom;
        for (int n = 0; n < 3; n++) begin
            req = 4'b1001;
            tick();
            n_run++; if (tx_start !== 1'b1 || grant_id !== exp_seq[n][1:0]) begin n_fail++; $display("FAIL wrap[%0d]: got start=%b id=%0d expected 1/%0d", n, tx_start, grant_id, exp_seq[n]); end
            req = 4'b0000;
            repeat (3) tick();
            pulse_done();
        end
    endtask

    task automatic test_done_ignored();
        logic saw;
        do_reset();
        pulse_done();
        n_run++; if (busy !== 1'b0 || tx_start !== 1'b0 || req_ack !== 4'b0000) begin n_fail++; $display("FAIL done_in_idle: busy=%b start=%b ack=%b expected 0/0/0000", busy, tx_start, req_ack); end
        req_data = $urandom;
        req = 4'b0010;
        tick();
        n_run++; if (tx_start !== 1'b1 || grant_id !== 2'd1) begin n_fail++; $display("FAIL done_start_grant: start=%b id=%0d expected 1/1", tx_start, grant_id); end
        req = 4'b0000;
        tx_done = 1'b1;   // arrives during START
        tick();
        tx_done = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b1 || tx_start !== 1'b0) saw = 1'b1;
            tick();
        end
        n_run++; if (saw !== 1'b0) begin n_fail++; $display("FAIL done_in_start: busy dropped or extra tx_start seen=%b expected 0", saw); end
        pulse_done();
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_after_ignore: busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data = $urandom;
        req = 4'b0010;
        tick();                      // START, grant 1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0000;
        n_run++; if (tx_start !== 1'b0 || req_ack !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_in_start: start=%b ack=%b busy=%b expected 0/0000/0", tx_start, req_ack, busy); end
        tick();
        req = 4'b0010;
        tick();                      // grant 1 -> last_grant 1
        req = 4'b1101;               // pending requests during WAIT
        repeat (11) tick();          // START plus 10 cycles into WAIT
        rst = 1'b1;
        tick();
        n_run++; if (tx_start !== 1'b0 || req_ack !== 4'b0000 || busy !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_in_wait_ctrl: start=%b ack=%b busy=%b terr=%b expected all 0", tx_start, req_ack, busy, timeout_err); end
        n_run++; if (tx_data !== 8'h00 || grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_in_wait_data: data=%h id=%0d expected 00/0", tx_data, grant_id); end
        tick();
        n_run++; if (busy !== 1'b0 || tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_hold_no_grant: busy=%b start=%b expected 0/0", busy, tx_start); end
        rst = 1'b0;
        m_last = 3;
        tick();
        n_run++; if (tx_start !== 1'b1 || grant_id !== 2'(rr_pick(m_last, 4'b1101))) begin n_fail++; $display("FAIL reset_last_grant: start=%b id=%0d expected 1/%0d", tx_start, grant_id, rr_pick(m_last, 4'b1101)); end
        req = 4'b0000;
        repeat (2) tick();
        pulse_done();
    endtask

    task automatic test_drop();
        logic saw_ack1, saw_start;
        do_reset();
        req_data = $urandom;
        req = 4'b0001;
        tick();
        n_run++; if (req_ack !== 4'b0001 || grant_id !== 2'd0) begin n_fail++; $display("FAIL drop_first_grant: ack=%b id=%0d expected 0001/0", req_ack, grant_id); end
        req = 4'b0000;
        saw_ack1 = 1'b0;
        saw_start = 1'b0;
        tick();
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            saw_ack1 |= req_ack[1];
            saw_start |= tx_start;
            tick();
        end
        req = 4'b0000;
        tick();
        pulse_done();
        for (int i = 0; i < 20; i++) begin
            saw_ack1 |= req_ack[1];
            saw_start |= tx_start;
            tick();
        end
        n_run++; if (saw_ack1 !== 1'b0)  begin n_fail++; $display("FAIL drop_ack1: got %b expected 0", saw_ack1); end
        n_run++; if (saw_start !== 1'b0) begin n_fail++; $display("FAIL drop_start: got %b expected 0", saw_start); end
    endtask

    task automatic test_timeout();
        do_reset();
        req_data = $urandom;
        req = 4'b0100;
        tick();                      // START
        req = 4'b0000;
        tick();                      // first WAIT cycle
`ifdef UART_ARB_TIMEOUT_EN
        repeat (c_TIMEOUT - 1) tick();
        n_run++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early: terr=%b busy=%b expected 0/1", timeout_err, busy); end
        tick();
        n_run++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_expiry: terr=%b busy=%b expected 1/0", timeout_err, busy); end
        tick();
        n_run++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse_width: terr=%b expected 0", timeout_err); end
`else
        begin
            logic bad = 1'b0;
            for (int i = 0; i < 2 * c_TIMEOUT; i++) begin
                if (busy !== 1'b1 || timeout_err !== 1'b0) bad = 1'b1;
                tick();
            end
            n_run++; if (bad !== 1'b0) begin n_fail++; $display("FAIL no_timeout_wait: left WAIT or terr seen=%b expected 0", bad); end
        end
        pulse_done();
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL no_timeout_done: busy=%b expected 0", busy); end
`endif
    endtask

    task automatic test_random();
        logic [3:0] pending;
        logic [3:0] mask;
        int exp;
        do_reset();
        pending = 4'b0000;
        for (int n = 0; n < 40; n++) begin
            mask = pending | 4'($urandom_range(0, 15));
            if (mask == 4'b0000) mask = 4'b0001 << $urandom_range(0, 3);
            req_data = $urandom;
            req = mask;
            tick();
            exp = rr_pick(m_last, mask);
            m_last = exp;
            n_run++; if (tx_start !== 1'b1 || grant_id !== exp[1:0] || req_ack !== (4'b0001 << exp) || tx_data !== req_data[exp*8 +: 8]) begin
                n_fail++;
                $display("FAIL rand[%0d]: start=%b id=%0d ack=%b data=%h expected 1/%0d/%b/%h", n, tx_start, grant_id, req_ack, tx_data, exp, 4'b0001 << exp, req_data[exp*8 +: 8]);
            end
            pending = mask & ~(4'b0001 << exp);
            req = pending;
            tick();
            repeat ($urandom_range(0, 5)) tick();
            pulse_done();
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        req      = 4'b0000;
        req_data = 32'h0;
        tx_done  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_done_ignored();
        test_reset_mid();
        test_drop();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not finish within 1 ms");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter: NREQ, 4, number of requesters (fixed at 4 in this revision).
REQ-002 SHALL have parameter: TIMEOUT_CYC, 20000, maximum cycles to wait for tx_done (used only with UART_ARB_TIMEOUT_EN).
REQ-003 SHALL have port: sys_clk  input  1  system clock (125 MHz); all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: req  input  4  per-requester send request, level, held until ack.
REQ-006 SHALL have port: req_data  input  32  requester i byte at bits [8i+7:8i], stable while req[i] high.
REQ-007 SHALL have port: req_ack  output  4  one-cycle pulse to the requester whose byte was accepted.
REQ-008 SHALL have port: tx_start  output  1  one-cycle start pulse to the UART transmitter.
REQ-009 SHALL have port: tx_data  output  8  byte to transmit; registered, held from tx_start until the next grant.
REQ-010 SHALL have port: tx_done  input  1  one-cycle pulse from the transmitter at the end of the stop bit.
REQ-011 SHALL have port: grant_id  output  2  index of the requester currently or last served.
REQ-012 SHALL have port: busy  output  1  high in states START and WAIT.
REQ-013 SHALL have port: timeout_err  output  1  one-cycle pulse on watchdog expiry.

Function
REQ-014 SHALL implement FSM states IDLE, START, WAIT.
REQ-015 IDLE: if any req bit is high, SHALL select a winner, latch its byte into tx_data, set grant_id, and go to START; otherwise remain in IDLE.
REQ-016 START: SHALL assert tx_start=1 and req_ack[grant_id]=1 for exactly this one cycle, then go to WAIT.
REQ-017 WAIT: SHALL remain until tx_done=1, then go to IDLE on the next edge.
REQ-018 Latency: req sampled high in IDLE at edge n SHALL produce tx_start and ack during cycle n+1; the next grant SHALL occur no earlier than the edge after tx_done.
REQ-019 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 4 and wraps; last_grant updates only on a grant.
REQ-020 After reset, last_grant SHALL be 3, so req[0] has the highest priority.
REQ-021 Wrap-around: last_grant=3 with req=4'b1001 SHALL grant 0; last_grant=0 with req=4'b1001 SHALL grant 3.
REQ-022 tx_done in IDLE or START SHALL be ignored, with no state or output change.
REQ-023 A req that drops before it is granted SHALL not be acked and SHALL not be transmitted.
REQ-024 A req that drops after the grant edge SHALL not affect the captured byte or the ack.
REQ-025 A requester SHALL not be granted twice in a row while any other req bit is high.

Reset
REQ-026 On rst=1 at an edge, the block SHALL set: state IDLE; tx_start=0; req_ack=0; tx_data=8'h00; grant_id=0; busy=0; timeout_err=0; last_grant=3; watchdog=0.
REQ-027 Reset mid-transfer (START or WAIT) SHALL abort to IDLE without issuing an ack; a pending tx_start SHALL be low from the reset edge onward.

Configuration
REQ-028 With macro UART_ARB_TIMEOUT_EN defined, the block SHALL run a watchdog: a counter cleared on entry to WAIT and incremented each WAIT cycle.
REQ-029 With UART_ARB_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYC-1 without tx_done, the FSM SHALL return to IDLE and timeout_err SHALL pulse for 1 cycle.
REQ-030 With UART_ARB_TIMEOUT_EN defined, tx_done in the same cycle as expiry SHALL take precedence: normal return to IDLE, no timeout_err pulse.
REQ-031 Without UART_ARB_TIMEOUT_EN, WAIT SHALL be unbounded; the timeout_err port SHALL remain present and be tied to 0; no counter logic SHALL be synthesized.

Verification
REQ-032 Scenario: after reset, req=4'b0100 with byte 8'hA5 -> one cycle later tx_start=1, tx_data=8'hA5, req_ack=4'b0100, grant_id=2; busy stays high until the edge after tx_done.
REQ-033 Scenario: req=4'b1111 held with bytes 11/22/33/44, tx_done returned 50 cycles after each start -> grant order 0,1,2,3,0 and tx_data 11,22,33,44,11.
REQ-034 Scenario: tx_done pulse injected in IDLE and in START -> no state change, and no extra tx_start.
REQ-035 Scenario: rst asserted 10 cycles into WAIT -> next cycle state IDLE, all outputs at reset values, last_grant=3; a pending req[3] is re-granted only after rst deasserts.
REQ-036 Scenario: UART_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=100, tx_done never returned -> timeout_err pulses 100 cycles after entry to WAIT and the FSM returns to IDLE; the same case without the macro -> FSM stays in WAIT and timeout_err stays 0.
REQ-037 Scenario: req[1] asserted then dropped during a busy transfer to requester 0 -> req_ack[1] never pulses and requester 1's byte is never sent.
